axil_initiator: RTL and testbench



---
 rtl/axil_initiator.sv | 197 +++++++++++++++++++
 tb/tb_axil_initiator.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_initiator.sv
// ---------------------------------------------------------------------------
// axil_initiator
//
// Bridges a simple single-outstanding request/response port (CPU load/store
// side) onto an AXI4-Lite manager interface. Only one transaction is in
// flight at a time. AW and W may complete in either order or together, and
// an early B or R response is held off until the matching response state.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_req_*  / o_req_ready request: valid, write, addr, wdata, wstrb
//   o_resp_* / i_resp_ready response: valid, rdata (0 for writes), err
//   o_aw* / i_awready      AXI write address channel
//   o_w*  / i_wready       AXI write data channel
//   i_b*  / o_bready       AXI write response channel
//   o_ar* / i_arready      AXI read address channel
//   i_r*  / o_rready       AXI read data channel
//
// Every output is decoded from registered state only, so there is no
// combinational path from any input to any output.
// DATA_WIDTH is expected to be 32 or 64.
// ---------------------------------------------------------------------------
module axil_initiator #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    input  logic [STRB_WIDTH-1:0] i_req_wstrb,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic [1:0]            o_resp_err,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [2:0]            o_awprot,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [2:0]            o_arprot,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [1:0]            r_resp_err;

    logic w_accept;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_aw_ok;
    logic w_w_ok;

    // Output decode: purely from state and the per-channel done flags.
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_awvalid    = (r_state == S_WR_REQ) && !r_aw_done;
    assign o_wvalid     = (r_state == S_WR_REQ) && !r_w_done;
    assign o_bready     = (r_state == S_WR_RESP);
    assign o_arvalid    = (r_state == S_RD_ADDR);
    assign o_rready     = (r_state == S_RD_DATA);
    assign o_resp_valid = (r_state == S_DONE);

    assign o_awaddr     = r_addr;
    assign o_araddr     = r_addr;
    assign o_wdata      = r_wdata;
    assign o_wstrb      = r_wstrb;
    assign o_awprot     = PROT;
    assign o_arprot     = PROT;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    assign w_accept  = o_req_ready && i_req_valid;
    assign w_aw_fire = o_awvalid && i_awready;
    assign w_w_fire  = o_wvalid && i_wready;

    // A channel counts as complete if it finished earlier or handshakes now,
    // so the write phase can end in the same cycle as the last handshake.
    assign w_aw_ok = r_aw_done || w_aw_fire;
    assign w_w_ok  = r_w_done || w_w_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_next = i_req_write ? S_WR_REQ : S_RD_ADDR;
                end
            end
            S_WR_REQ: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_next = S_WR_RESP;
                end
            end
            // An early bvalid seen in S_WR_REQ is simply left pending by the
            // responder and consumed here.
            S_WR_RESP: begin
                if (i_bvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (i_arready) begin
                    w_state_next = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_rvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (i_resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 2'b00;
        end else begin
            if (w_accept) begin
                r_addr    <= i_req_addr;
                r_wdata   <= i_req_wdata;
                r_wstrb   <= i_req_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_fire) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_fire) begin
                r_w_done <= 1'b1;
            end
            if (o_bready && i_bvalid) begin
                r_resp_rdata <= '0;
                r_resp_err   <= i_bresp;
            end
            if (o_rready && i_rvalid) begin
                r_resp_rdata <= i_rdata;
                r_resp_err   <= i_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_initiator.sv
`timescale 1ns/1ps
module tb_axil_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_ready = 1'b0;

    logic        o_req_ready, o_resp_valid, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    logic [31:0] o_resp_rdata, o_awaddr, o_wdata, o_araddr;
    logic [1:0]  o_resp_err;
    logic [2:0]  o_awprot, o_arprot;
    logic [3:0]  o_wstrb;

    // Directed-test drivers (d*) and automatic responder drivers (a*)
    logic        autoMode = 1'b0;
    logic        dAwready = 0, dWready = 0, dBvalid = 0, dArready = 0, dRvalid = 0;
    logic [1:0]  dBresp = 0, dRresp = 0;
    logic [31:0] dRdata = 0;
    logic        aAwready = 0, aWready = 0, aBvalid = 0, aArready = 0, aRvalid = 0;
    logic [1:0]  aBresp = 0, aRresp = 0;
    logic [31:0] aRdata = 0;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    assign awready = autoMode ? aAwready : dAwready;
    assign wready  = autoMode ? aWready  : dWready;
    assign bvalid  = autoMode ? aBvalid  : dBvalid;
    assign bresp   = autoMode ? aBresp   : dBresp;
    assign arready = autoMode ? aArready : dArready;
    assign rvalid  = autoMode ? aRvalid  : dRvalid;
    assign rresp   = autoMode ? aRresp   : dRresp;
    assign rdata   = autoMode ? aRdata   : dRdata;

    int checks = 0;
    int passed = 0;
    logic aborted = 1'b0;

    axil_initiator dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
        .o_resp_valid(o_resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(wready),
        .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(arready),
        .i_rdata(rdata), .i_rresp(rresp), .i_rvalid(rvalid), .o_rready(o_rready)
    );

    // Advance to 1ns after the next rising edge: outputs of the new cycle are
    // settled, and inputs set now apply to this cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference memory for the requester side, responder memory for the slave
    logic [31:0] refMem [16];
    logic [31:0] respMem [16];

    // Responder state
    logic        awGot = 0, wGot = 0, bArmed = 0, bFire = 0, arGot = 0, rArmed = 0, rFire = 0;
    int          awDly = 0, wDly = 0, bDly = 0, arDly = 0, rDly = 0;
    logic [31:0] gotAwaddr = 0, gotWdata = 0, gotAraddr = 0;
    logic [3:0]  gotWstrb = 0;
    logic        pAwValid = 0, pAwFire = 0, pWValid = 0, pWFire = 0, pArValid = 0, pArFire = 0;
    logic [31:0] pAwaddr = 0, pWdata = 0, pAraddr = 0;

    // Randomly delayed AXI4-Lite slave; bresp/rresp come from address bits [5:4]
    initial begin : responder
        for (int j = 0; j < 16; j++) respMem[j] = 32'hA000_0000 + j;
        forever begin
            step();
            if (autoMode) begin
                if (pAwValid && !pAwFire) begin
                    checks++;
                    if (o_awvalid !== 1'b1 || o_awaddr !== pAwaddr)
                        $display("[TB] FAIL aw_stable: got valid %b addr %h expected 1 %h", o_awvalid, o_awaddr, pAwaddr);
                    else passed++;
                end
                aAwready = 1'b0;
                if (o_awvalid && !awGot) begin
                    if (awDly == 0) begin
                        aAwready = 1'b1; awGot = 1'b1; gotAwaddr = o_awaddr; awDly = $urandom_range(0, 5);
                    end else awDly--;
                end
                pAwValid = o_awvalid; pAwaddr = o_awaddr; pAwFire = o_awvalid && aAwready;

                if (pWValid && !pWFire) begin
                    checks++;
                    if (o_wvalid !== 1'b1 || o_wdata !== pWdata)
                        $display("[TB] FAIL w_stable: got valid %b data %h expected 1 %h", o_wvalid, o_wdata, pWdata);
                    else passed++;
                end
                aWready = 1'b0;
                if (o_wvalid && !wGot) begin
                    if (wDly == 0) begin
                        aWready = 1'b1; wGot = 1'b1; gotWdata = o_wdata; gotWstrb = o_wstrb;
                        wDly = $urandom_range(0, 5);
                    end else wDly--;
                end
                pWValid = o_wvalid; pWdata = o_wdata; pWFire = o_wvalid && aWready;

                if (bFire) begin
                    aBvalid = 1'b0; bArmed = 1'b0; awGot = 1'b0; wGot = 1'b0; bFire = 1'b0;
                end
                if (awGot && wGot && !bArmed) begin
                    bArmed = 1'b1; bDly = $urandom_range(0, 5);
                end
                if (bArmed && !aBvalid) begin
                    if (bDly == 0) begin
                        aBvalid = 1'b1;
                        aBresp = gotAwaddr[5:4];
                        for (int b = 0; b < 4; b++)
                            if (gotWstrb[b]) respMem[gotAwaddr[5:2]][8*b +: 8] = gotWdata[8*b +: 8];
                    end else bDly--;
                end
                bFire = aBvalid && o_bready;

                if (pArValid && !pArFire) begin
                    checks++;
                    if (o_arvalid !== 1'b1 || o_araddr !== pAraddr)
                        $display("[TB] FAIL ar_stable: got valid %b addr %h expected 1 %h", o_arvalid, o_araddr, pAraddr);
                    else passed++;
                end
                aArready = 1'b0;
                if (o_arvalid && !arGot) begin
                    if (arDly == 0) begin
                        aArready = 1'b1; arGot = 1'b1; gotAraddr = o_araddr; arDly = $urandom_range(0, 5);
                    end else arDly--;
                end
                pArValid = o_arvalid; pAraddr = o_araddr; pArFire = o_arvalid && aArready;

                if (rFire) begin
                    aRvalid = 1'b0; rArmed = 1'b0; arGot = 1'b0; rFire = 1'b0;
                end
                if (arGot && !rArmed) begin
                    rArmed = 1'b1; rDly = $urandom_range(0, 5);
                end
                if (rArmed && !aRvalid) begin
                    if (rDly == 0) begin
                        aRvalid = 1'b1; aRdata = respMem[gotAraddr[5:2]]; aRresp = gotAraddr[5:4];
                    end else rDly--;
                end
                rFire = aRvalid && o_rready;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        checks++;
        if (o_req_ready !== 1'b1) $display("[TB] FAIL rst_req_ready: got %b expected 1", o_req_ready);
        else passed++;
        checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_resp_valid} !== 6'b0)
            $display("[TB] FAIL rst_handshakes: got %b expected 000000",
                     {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_resp_valid});
        else passed++;
        checks++;
        if ({o_awaddr, o_araddr, o_wdata, o_wstrb} !== 100'd0)
            $display("[TB] FAIL rst_holding: got %h expected 0", {o_awaddr, o_araddr, o_wdata, o_wstrb});
        else passed++;
        checks++;
        if ({o_resp_rdata, o_resp_err, o_awprot, o_arprot} !== 40'd0)
            $display("[TB] FAIL rst_resp_prot: got %h expected 0", {o_resp_rdata, o_resp_err, o_awprot, o_arprot});
        else passed++;
    endtask

    task automatic test_zero_wait_write();
        req_valid = 1; req_write = 1; req_addr = 32'h0; req_wdata = 32'h41; req_wstrb = 4'hF;
        dAwready = 1; dWready = 1;
        step(); // cycle 1
        req_valid = 0;
        checks++;
        if ({o_awvalid, o_wvalid, o_req_ready} !== 3'b110)
            $display("[TB] FAIL zw_wr_c1_valids: got %b expected 110", {o_awvalid, o_wvalid, o_req_ready});
        else passed++;
        checks++;
        if (o_wdata !== 32'h41 || o_wstrb !== 4'hF)
            $display("[TB] FAIL zw_wr_c1_wdata: got %h/%h expected 00000041/f", o_wdata, o_wstrb);
        else passed++;
        step(); // cycle 2
        dAwready = 0; dWready = 0; dBvalid = 1; dBresp = 2'b00;
        checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_resp_valid} !== 4'b0010)
            $display("[TB] FAIL zw_wr_c2: got %b expected 0010", {o_awvalid, o_wvalid, o_bready, o_resp_valid});
        else passed++;
        step(); // cycle 3
        dBvalid = 0;
        checks++;
        if ({o_resp_valid, o_bready, o_resp_err, o_resp_rdata} !== {1'b1, 1'b0, 2'b00, 32'h0})
            $display("[TB] FAIL zw_wr_c3_resp: got %b %b %b %h expected 1 0 00 0",
                     o_resp_valid, o_bready, o_resp_err, o_resp_rdata);
        else passed++;
        resp_ready = 1;
        step(); // cycle 4
        resp_ready = 0;
        checks++;
        if ({o_req_ready, o_resp_valid} !== 2'b10)
            $display("[TB] FAIL zw_wr_c4_idle: got %b expected 10", {o_req_ready, o_resp_valid});
        else passed++;
    endtask

    task automatic test_zero_wait_read();
        req_valid = 1; req_write = 0; req_addr = 32'h4;
        step(); // cycle 1
        req_valid = 0; dArready = 1;
        checks++;
        if (o_arvalid !== 1'b1 || o_araddr !== 32'h4 || o_awvalid !== 1'b0)
            $display("[TB] FAIL zw_rd_c1: got arvalid %b araddr %h awvalid %b expected 1 4 0",
                     o_arvalid, o_araddr, o_awvalid);
        else passed++;
        step(); // cycle 2
        dArready = 0; dRvalid = 1; dRdata = 32'h3; dRresp = 2'b00;
        checks++;
        if ({o_arvalid, o_rready} !== 2'b01)
            $display("[TB] FAIL zw_rd_c2: got %b expected 01", {o_arvalid, o_rready});
        else passed++;
        step(); // cycle 3
        dRvalid = 0;
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_rdata !== 32'h3 || o_resp_err !== 2'b00)
            $display("[TB] FAIL zw_rd_c3: got %b %h %b expected 1 00000003 00", o_resp_valid, o_resp_rdata, o_resp_err);
        else passed++;
        resp_ready = 1;
        step(); // cycle 4
        resp_ready = 0;
        checks++;
        if (o_req_ready !== 1'b1) $display("[TB] FAIL zw_rd_c4: got %b expected 1", o_req_ready);
        else passed++;
    endtask

    task automatic test_skewed_write();
        req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'h5;
        step(); // cycle 1
        req_valid = 0; dWready = 1; dAwready = 0; dBvalid = 1; dBresp = 2'b11;
        checks++;
        if ({o_awvalid, o_wvalid} !== 2'b11)
            $display("[TB] FAIL skew_c1: got %b expected 11", {o_awvalid, o_wvalid});
        else passed++;
        step(); // cycle 2
        dWready = 0;
        for (int c = 2; c <= 4; c++) begin
            checks++;
            if ({o_awvalid, o_wvalid, o_bready} !== 3'b100)
                $display("[TB] FAIL skew_wait_c%0d: got %b expected 100", c, {o_awvalid, o_wvalid, o_bready});
            else passed++;
            checks++;
            if (o_awaddr !== 32'h10)
                $display("[TB] FAIL skew_awaddr_c%0d: got %h expected 00000010", c, o_awaddr);
            else passed++;
            if (c == 4) dAwready = 1;
            step();
        end
        // cycle 5
        dAwready = 0;
        checks++;
        if ({o_awvalid, o_bready, o_resp_valid} !== 3'b010)
            $display("[TB] FAIL skew_c5: got %b expected 010", {o_awvalid, o_bready, o_resp_valid});
        else passed++;
        step(); // cycle 6
        dBvalid = 0;
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_err !== 2'b11 || o_resp_rdata !== 32'h0)
            $display("[TB] FAIL skew_c6: got %b %b %h expected 1 11 0", o_resp_valid, o_resp_err, o_resp_rdata);
        else passed++;
        resp_ready = 1;
        step();
        resp_ready = 0;
        checks++;
        if (o_req_ready !== 1'b1) $display("[TB] FAIL skew_idle: got %b expected 1", o_req_ready);
        else passed++;
    endtask

    task automatic test_resp_stall();
        req_valid = 1; req_write = 0; req_addr = 32'h8;
        step(); // cycle 1
        req_valid = 0; dArready = 1;
        step(); // cycle 2
        dArready = 0; dRvalid = 1; dRdata = 32'h55AA_1234; dRresp = 2'b10;
        step(); // cycle 3
        dRvalid = 0;
        req_valid = 1; req_write = 1; req_addr = 32'h40; req_wdata = 32'h1;
        for (int c = 3; c <= 6; c++) begin
            checks++;
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== 32'h55AA_1234 || o_resp_err !== 2'b10)
                $display("[TB] FAIL stall_resp_c%0d: got %b %h %b expected 1 55aa1234 10",
                         c, o_resp_valid, o_resp_rdata, o_resp_err);
            else passed++;
            checks++;
            if (o_req_ready !== 1'b0) $display("[TB] FAIL stall_req_ready_c%0d: got %b expected 0", c, o_req_ready);
            else passed++;
            if (c == 6) begin
                resp_ready = 1; req_valid = 0;
            end
            step();
        end
        // cycle 7
        resp_ready = 0;
        checks++;
        if ({o_req_ready, o_resp_valid, o_awvalid, o_arvalid} !== 4'b1000)
            $display("[TB] FAIL stall_c7: got %b expected 1000", {o_req_ready, o_resp_valid, o_awvalid, o_arvalid});
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1; req_write = 0; req_addr = 32'hC;
        step(); // cycle 1
        req_valid = 0; dArready = 1;
        step(); // cycle 2, waiting in the read-data phase
        dArready = 0;
        checks++;
        if (o_rready !== 1'b1) $display("[TB] FAIL midrst_rready: got %b expected 1", o_rready);
        else passed++;
        rst = 1;
        step();
        checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_resp_valid, o_req_ready} !== 7'b0000001)
            $display("[TB] FAIL midrst_outputs: got %b expected 0000001",
                     {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_resp_valid, o_req_ready});
        else passed++;
        checks++;
        if (o_araddr !== 32'h0) $display("[TB] FAIL midrst_araddr: got %h expected 0", o_araddr);
        else passed++;
        rst = 0;
        step();
        req_valid = 1; req_write = 1; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'h3;
        step(); // cycle 1
        req_valid = 0; dAwready = 1; dWready = 1;
        checks++;
        if ({o_awvalid, o_wvalid} !== 2'b11 || o_awaddr !== 32'h24)
            $display("[TB] FAIL postrst_c1: got %b %h expected 11 00000024", {o_awvalid, o_wvalid}, o_awaddr);
        else passed++;
        step(); // cycle 2
        dAwready = 0; dWready = 0; dBvalid = 1; dBresp = 2'b01;
        step(); // cycle 3
        dBvalid = 0;
        checks++;
        if (o_resp_valid !== 1'b1 || o_resp_err !== 2'b01 || o_resp_rdata !== 32'h0)
            $display("[TB] FAIL postrst_resp: got %b %b %h expected 1 01 0", o_resp_valid, o_resp_err, o_resp_rdata);
        else passed++;
        resp_ready = 1;
        step();
        resp_ready = 0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] lastIdx = 4'd0;
        for (int j = 0; j < 16; j++) refMem[j] = 32'hA000_0000 + j;
        autoMode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [3:0]  idx;
            logic [31:0] wd;
            logic [3:0]  ws;
            logic [31:0] expData;
            logic [1:0]  expErr;
            int          gap, dly, budget;
            if (aborted) break;
            idx = 4'($urandom_range(0, 15));
            if ((i % 2 == 1) && ($urandom_range(0, 1) == 1)) idx = lastIdx;
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            gap = $urandom_range(0, 5);
            repeat (gap) step();
            budget = 0;
            while (o_req_ready !== 1'b1 && budget < 50) begin
                step();
                budget++;
            end
            if (o_req_ready !== 1'b1) begin
                checks++;
                $display("[TB] FAIL b2b_req_ready_timeout: got %b expected 1 (req %0d)", o_req_ready, i);
                aborted = 1'b1;
                break;
            end
            req_valid = 1; req_write = (i % 2 == 0); req_addr = {26'd0, idx, 2'b00};
            req_wdata = wd; req_wstrb = ws;
            expErr = idx[3:2];
            if (i % 2 == 0) begin
                expData = 32'h0;
                for (int b = 0; b < 4; b++) if (ws[b]) refMem[idx][8*b +: 8] = wd[8*b +: 8];
                lastIdx = idx;
            end else begin
                expData = refMem[idx];
            end
            step();
            req_valid = 0;
            dly = $urandom_range(0, 5);
            budget = 0;
            while (budget < 200) begin
                if (o_resp_valid === 1'b1) begin
                    if (dly == 0) break;
                    dly--;
                end
                step();
                budget++;
            end
            checks++;
            if (o_resp_valid !== 1'b1) begin
                $display("[TB] FAIL b2b_resp_timeout: got %b expected 1 (req %0d)", o_resp_valid, i);
                aborted = 1'b1;
                break;
            end else passed++;
            checks++;
            if (o_resp_rdata !== expData)
                $display("[TB] FAIL b2b_rdata req %0d: got %h expected %h", i, o_resp_rdata, expData);
            else passed++;
            checks++;
            if (o_resp_err !== expErr)
                $display("[TB] FAIL b2b_err req %0d: got %b expected %b", i, o_resp_err, expErr);
            else passed++;
            resp_ready = 1;
            step();
            resp_ready = 0;
        end
        autoMode = 1'b0;
        repeat (2) step();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        test_reset();
        test_zero_wait_write();
        test_zero_wait_read();
        test_skewed_write();
        test_resp_stall();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
